// File: rtl/text_console_pkg.sv
// Shared constants, control codes and FSM state encoding for the text console writer.
package text_console_pkg;
    localparam int COLS  = 64;
    localparam int ROWS  = 32;
    localparam int CELLS = COLS * ROWS;

    localparam logic [7:0] CHR_BS = 8'h08;
    localparam logic [7:0] CHR_LF = 8'h0A;
    localparam logic [7:0] CHR_FF = 8'h0C;
    localparam logic [7:0] CHR_CR = 8'h0D;

    typedef enum logic [1:0] {
        IDLE,
        CLR_LINE,
        CLR_SCREEN
    } state_t;
endpackage

// File: rtl/console_cursor.sv
// Cursor position and scroll offset; maps the logical cursor to a physical buffer address.
module console_cursor #(
    parameter int COLS_LOG2 = 6,
    parameter int ROWS_LOG2 = 5
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_cr,
    input  logic                           i_lf,
    input  logic                           i_bs,
    input  logic                           i_adv,
    input  logic                           i_home,
    output logic [ROWS_LOG2-1:0]           o_top_row,
    output logic                           o_at_right,
    output logic                           o_at_bottom,
    output logic [COLS_LOG2+ROWS_LOG2-1:0] o_cursor_addr
);
    localparam logic [COLS_LOG2-1:0] COL_ONE = 1;
    localparam logic [ROWS_LOG2-1:0] ROW_ONE = 1;

    logic [COLS_LOG2-1:0] col_q, col_d;
    logic [ROWS_LOG2-1:0] row_q, row_d;
    logic [ROWS_LOG2-1:0] top_q, top_d;
    logic [ROWS_LOG2-1:0] phys_row;
    logic                 newline;

    assign o_at_right  = (col_q == '1);
    assign o_at_bottom = (row_q == '1);
    assign newline     = i_lf | (i_adv & o_at_right);

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        top_d = top_q;
        if (i_home) begin
            col_d = '0;
            row_d = '0;
            top_d = '0;
        end else begin
            if (i_cr) begin
                col_d = '0;
            end else if (i_bs && (col_q != '0)) begin
                col_d = col_q - COL_ONE;
            end else if (i_adv) begin
                col_d = col_q + COL_ONE;
            end
            // At the bottom row the screen scrolls instead of the cursor moving.
            if (newline) begin
                if (o_at_bottom) top_d = top_q + ROW_ONE;
                else             row_d = row_q + ROW_ONE;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            col_q <= '0;
            row_q <= '0;
            top_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
            top_q <= top_d;
        end
    end

    assign phys_row      = row_q + top_q;
    assign o_top_row     = top_q;
    assign o_cursor_addr = {phys_row, col_q};
endmodule

// File: rtl/text_console_writer.sv
// Port-A write master for the character buffer: terminal-style byte interpreter with hardware scroll.
// state      | meaning
// IDLE       | accepting bytes, one per cycle
// CLR_LINE   | blanking the physical row that just became the bottom line
// CLR_SCREEN | blanking the whole buffer, then homing cursor and scroll offset
module text_console_writer
    import text_console_pkg::*;
#(
    parameter int         COLS_LOG2  = 6,
    parameter int         ROWS_LOG2  = 5,
    parameter logic [7:0] BLANK_CHAR = 8'h20
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic [7:0]                     i_data,
    input  logic                           i_valid,
    output logic                           o_ready,
    output logic [COLS_LOG2+ROWS_LOG2-1:0] o_address,
    output logic [7:0]                     o_data,
    output logic                           o_we,
    output logic [ROWS_LOG2-1:0]           o_top_row,
    output logic [COLS_LOG2+ROWS_LOG2-1:0] o_cursor_addr
);
    localparam int              AW      = COLS_LOG2 + ROWS_LOG2;
    localparam logic [AW-1:0]   CNT_ONE = 1;

    state_t                state_q, state_d;
    logic [AW-1:0]         cnt_q, cnt_d;
    logic [ROWS_LOG2-1:0]  clr_row_q, clr_row_d;
    logic                  we_q, we_d;
    logic [AW-1:0]         addr_q, addr_d;
    logic [7:0]            data_q, data_d;
    logic                  ready_q, ready_d;

    logic                  accept;
    logic                  cur_cr, cur_lf, cur_bs, cur_adv, cur_home;
    logic [ROWS_LOG2-1:0]  top_row;
    logic                  at_right, at_bottom;
    logic [AW-1:0]         cursor_addr;

    assign accept = i_valid & ready_q;

    console_cursor #(
        .COLS_LOG2 (COLS_LOG2),
        .ROWS_LOG2 (ROWS_LOG2)
    ) u_cursor (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_cr          (cur_cr),
        .i_lf          (cur_lf),
        .i_bs          (cur_bs),
        .i_adv         (cur_adv),
        .i_home        (cur_home),
        .o_top_row     (top_row),
        .o_at_right    (at_right),
        .o_at_bottom   (at_bottom),
        .o_cursor_addr (cursor_addr)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        clr_row_d = clr_row_q;
        we_d      = 1'b0;
        addr_d    = addr_q;
        data_d    = data_q;
        cur_cr    = 1'b0;
        cur_lf    = 1'b0;
        cur_bs    = 1'b0;
        cur_adv   = 1'b0;
        cur_home  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    case (i_data)
                        CHR_CR: cur_cr = 1'b1;
                        CHR_BS: cur_bs = 1'b1;
                        CHR_FF: begin
                            cnt_d   = '0;
                            state_d = CLR_SCREEN;
                        end
                        CHR_LF: begin
                            cur_lf = 1'b1;
                            // Scroll: the first blank of the old top row goes out with the LF itself.
                            if (at_bottom) begin
                                we_d      = 1'b1;
                                addr_d    = {top_row, {COLS_LOG2{1'b0}}};
                                data_d    = BLANK_CHAR;
                                clr_row_d = top_row;
                                cnt_d     = CNT_ONE;
                                state_d   = CLR_LINE;
                            end
                        end
                        default: begin
                            we_d    = 1'b1;
                            addr_d  = cursor_addr;
                            data_d  = i_data;
                            cur_adv = 1'b1;
                            if (at_right && at_bottom) begin
                                clr_row_d = top_row;
                                cnt_d     = '0;
                                state_d   = CLR_LINE;
                            end
                        end
                    endcase
                end
            end
            CLR_LINE: begin
                we_d   = 1'b1;
                addr_d = {clr_row_q, cnt_q[COLS_LOG2-1:0]};
                data_d = BLANK_CHAR;
                cnt_d  = cnt_q + CNT_ONE;
                if (cnt_q[COLS_LOG2-1:0] == '1) state_d = IDLE;
            end
            CLR_SCREEN: begin
                we_d   = 1'b1;
                addr_d = cnt_q;
                data_d = BLANK_CHAR;
                cnt_d  = cnt_q + CNT_ONE;
                if (cnt_q == '1) begin
                    cur_home = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = CLR_SCREEN;
        endcase
        // Ready only after a full cycle in IDLE, so it rises the cycle after the last clear write.
        ready_d = (state_d == IDLE) && (state_q == IDLE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= CLR_SCREEN;
            cnt_q     <= '0;
            clr_row_q <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            clr_row_q <= clr_row_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            ready_q   <= ready_d;
        end
    end

    assign o_ready       = ready_q;
    assign o_we          = we_q;
    assign o_address     = addr_q;
    assign o_data        = data_q;
    assign o_top_row     = top_row;
    assign o_cursor_addr = cursor_addr;
endmodule

// File: doc/text_console_writer.md
Name: text_console_writer

Overview:
Write-side master for the 64x32 monochrome character buffer; drives port A (address/data/write-enable) that the video path reads on port B.
Accepts a byte stream over a valid/ready handshake and acts as a minimal terminal:
- writes glyph codes at the cursor
- interprets CR, LF, BS and FF
- scrolls in hardware by rotating a top-row offset that the read path adds to y_cell.
Replaces the demo writer as the buffer's port-A source; runs on LCD_CLK.

Parameters:
COLS_LOG2, 6, log2 of columns (64); column field width of the address
ROWS_LOG2, 5, log2 of rows (32); row field width of the address
BLANK_CHAR, 8'h20, code written when clearing cells

Ports:
i_clk  in  1  pixel clock (LCD_CLK)
i_rst_n  in  1  asynchronous active-low reset
i_data  in  8  incoming character/control code
i_valid  in  1  i_data valid
o_ready  out  1  block can accept a byte this cycle
o_address  out  11  buffer write address {phys_row[4:0], col[5:0]}
o_data  out  8  buffer write data
o_we  out  1  buffer write enable (drives cea)
o_top_row  out  5  physical row shown at screen row 0; reader uses y_cell+o_top_row mod 32
o_cursor_addr  out  11  physical address of cursor cell, for a cursor overlay

Behaviour:
- Reset (async, i_rst_n=0):
  - o_we=0, o_address=0, o_data=0, o_ready=0, o_top_row=0
  - cursor col=0, row=0; state=CLR_SCREEN, clear counter=0
- States: IDLE, CLR_LINE, CLR_SCREEN. o_ready=1 only in IDLE. Bytes are accepted only when i_valid&o_ready.
- Address mapping:
  - phys_row=(row+top_row) mod 32, 5-bit wrap.
  - o_address and o_cursor_addr={phys_row,col}.
- CLR_SCREEN:
  - One write per cycle of BLANK_CHAR to addresses 0..2047 ascending; o_we=1 for exactly 2048 cycles.
  - Afterwards: top_row=0, col=0, row=0, then IDLE; o_ready rises the cycle after the last write.
- Accepted byte handling (all registered; effect visible next cycle):
  - 0x0D CR: col=0. No write.
  - 0x0A LF: newline (below). col unchanged. No write.
  - 0x08 BS: if col>0 then col-1, else no-op. No erase, no write.
  - 0x0C FF: enter CLR_SCREEN.
  - Any other code, including 0x00-0x1F except the above and 0x80-0xFF:
    - o_we=1, o_data=code, o_address=current cursor, one cycle after acceptance.
    - Cursor then advances: col+1. If col was 63, col=0 and newline.
- Newline:
  - if row<31: row+1.
  - if row=31 (scroll):
    - row stays 31; top_row increments mod 32.
    - enter CLR_LINE, which clears physical row = old top_row (the new bottom line), cols 0..63, 64 write cycles.
    - o_ready=0 from the cycle after acceptance until the cycle after the last clear write.
- A printable byte that wraps at (63,31): the glyph write happens first, then the 64 clear writes start the following cycle.
- Back-to-back printables in IDLE: sustained 1 byte/cycle; o_ready stays high.
- o_we=0 whenever no write is pending; o_data/o_address hold their last value when o_we=0.
- i_valid/i_data are ignored while o_ready=0. The source must hold them; no byte is lost or duplicated.
- o_top_row wraps 31->0 without special handling.
- Reset asserted mid-clear aborts the clear immediately and restarts full CLR_SCREEN after release.

Decomposition:
- Package text_console_pkg holds:
  - constants COLS=64, ROWS=32, CELLS=2048
  - control codes CHR_CR=8'h0D, CHR_LF=8'h0A, CHR_BS=8'h08, CHR_FF=8'h0C
  - state enum {IDLE, CLR_LINE, CLR_SCREEN}
- One natural sub-module, console_cursor: holds col/row/top_row and computes the newline/scroll condition and physical address. The top level holds the FSM, clear counter and write port.

Test Plan:
1. Release reset -> exactly 2048 o_we pulses, addresses 0..2047, data 0x20; o_ready rises cycle 2049; o_top_row=0.
2. Send 'A' (0x41), 'B' back-to-back -> writes (0x000,0x41) and (0x001,0x42) on consecutive cycles; o_ready never drops; o_cursor_addr=0x002.
3. Send 0x41, CR, LF, 0x42 -> writes 0x000=0x41, then 0x040=0x42; no writes for CR/LF.
4. Send 64 bytes of 0x58 from (0,0) -> last at 0x03F; cursor 0x040. BS at col 0 -> cursor unchanged; BS after one more char -> cursor returns to 0x040.
5. Cursor at row 31, top_row=0, send LF -> o_ready low for 64 cycles, writes 0x20 to 0x000..0x03F, o_top_row=1, o_cursor_addr=0x000 (row 31 phys 0), col preserved.
6. With i_valid held high during CLR_LINE -> byte accepted only after o_ready returns, written once. FF mid-stream -> full clear, cursor 0x000, top_row 0.
